// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// The register window holds TXDATA at +0 (write pushes a byte, read returns 0)
// and STATUS at +4 (read only). Bytes are held in a small circular FIFO and
// sent LSB first by a four-state serialiser.
//
// Bus handshake: there is no stall. A store (dmem_wren) or load (dmem_rden)
// that hits the window is accepted in the cycle it is presented. Load data
// appears on dmem_data_out after the next clock edge and holds until the next
// load that hits the window. A store to a full FIFO is dropped, unless the
// serialiser pops in the same cycle; the drop sets the sticky overflow flag.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFE0,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  input  logic        dmem_rden,
  output logic [31:0] dmem_data_out,
  output logic        tx,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [29:0] TX_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] ST_WORD = TX_WORD + 30'd1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Snapshot of the serialiser for assertions and probes bound from outside.
  typedef struct packed {
    state_t          state;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud;
    logic [CW-1:0]   count;
  } fsm_dbg_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;

  logic            hit_tx, hit_st;
  logic            wr_req, rd_st, rd_tx;
  logic            full, empty;
  logic            push, pop, drop;
  logic            baud_end;
  logic [31:0]     status_word;
  fsm_dbg_t        fsm_dbg;
  logic            unused_bits;

  // Byte lanes and store width are irrelevant: only the word address is
  // decoded and only byte [7:0] is taken. The debug snapshot is a probe point.
  assign unused_bits = ^{funct3, dmem_data_in[31:8], dmem_address[1:0], fsm_dbg};

  assign hit_tx = (dmem_address[31:2] == TX_WORD);
  assign hit_st = (dmem_address[31:2] == ST_WORD);
  assign wr_req = dmem_wren && hit_tx;
  assign rd_st  = dmem_rden && hit_st;
  assign rd_tx  = dmem_rden && hit_tx;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // A full FIFO still takes the byte when the serialiser frees a slot this cycle.
  assign push   = wr_req && (!full || pop);
  assign drop   = wr_req && full && !pop;

  assign busy   = (state_q != IDLE) || !empty;
  assign tx     = tx_q;

  assign status_word = {24'd0, 4'(count_q), ovf_q, busy, empty, full};
  assign fsm_dbg     = '{state: state_q, bit_idx: bit_q, baud: baud_q, count: count_q};

  // FIFO storage: written on every accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dmem_data_in[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow and registered read data; a drop in the reading cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q         <= 1'b0;
      dmem_data_out <= '0;
    end else begin
      if (drop)       ovf_q <= 1'b1;
      else if (rd_st) ovf_q <= 1'b0;
      if (rd_st)      dmem_data_out <= status_word;
      else if (rd_tx) dmem_data_out <= '0;
    end
  end

  // Serialiser state register, including the tx flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state logic: bit timing, shifting and FIFO pops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Back-to-back frames go straight into the next start bit.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the line level for the upcoming state, registered into tx_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
